// File: rtl/regfile_write_arbiter.sv
// Write-port controller for RegisterFile: round-robin req/ack arbitration between
// two requesters plus a zero-fill sweep of entries 1..2^M-1 after reset or on clear_req.
module regfile_write_arbiter #(
  parameter int M = 3,
  parameter int N = 4
) (
  input  logic         CLK100MHZ,
  input  logic         reset_n,
  input  logic         clear_req,
  output logic         busy,
  input  logic         req_a,
  input  logic [M-1:0] addr_a,
  input  logic [N-1:0] data_a,
  output logic         ack_a,
  input  logic         req_b,
  input  logic [M-1:0] addr_b,
  input  logic [N-1:0] data_b,
  output logic         ack_b,
  output logic         we,
  output logic [M-1:0] wa,
  output logic [N-1:0] wd
);

  typedef enum logic {CLEAR, ARB} state_e;
  typedef enum logic {SEL_A, SEL_B} sel_e;

  localparam logic [M-1:0] FIRST_ADDR = M'(1);
  localparam logic [M-1:0] LAST_ADDR  = '1;

  state_e       state, state_next;
  logic [M-1:0] counter, counter_next;
  sel_e         last_grant, last_grant_next;

  logic         elig_a, elig_b;
  logic         grant_a, grant_b;
  logic         we_next, ack_a_next, ack_b_next, busy_next;
  logic [M-1:0] wa_next;
  logic [N-1:0] wd_next;

  // A requester whose ack is currently high is still dropping req, so it is not eligible.
  assign elig_a  = req_a & ~ack_a;
  assign elig_b  = req_b & ~ack_b;
  assign grant_a = (state == ARB) & ~clear_req & elig_a & (~elig_b | (last_grant == SEL_B));
  assign grant_b = (state == ARB) & ~clear_req & elig_b & ~grant_a;

  // State register together with the registered outputs.
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state      <= CLEAR;
      counter    <= FIRST_ADDR;
      last_grant <= SEL_B;
      we         <= 1'b0;
      wa         <= '0;
      wd         <= '0;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      busy       <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_next;
      counter    <= counter_next;
      last_grant <= last_grant_next;
      we         <= we_next;
      wa         <= wa_next;
      wd         <= wd_next;
      ack_a      <= ack_a_next;
      ack_b      <= ack_b_next;
      busy       <= busy_next;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_next      = state;
    counter_next    = counter;
    last_grant_next = last_grant;
    case (state)
      CLEAR: begin
        counter_next = counter + FIRST_ADDR;
        if (counter == LAST_ADDR) state_next = ARB;
      end
      ARB: begin
        if (clear_req) begin
          state_next   = CLEAR;
          counter_next = FIRST_ADDR;
        end
      end
      default: state_next = CLEAR;
    endcase
    if (grant_a)      last_grant_next = SEL_A;
    else if (grant_b) last_grant_next = SEL_B;
  end

  // Output logic; results are registered above so no input reaches an output combinationally.
  always_comb begin
    we_next    = 1'b0;
    wa_next    = wa;
    wd_next    = wd;
    ack_a_next = grant_a;
    ack_b_next = grant_b;
    // Stays high through the last sweep write and rises on the clear_req edge itself.
    busy_next  = (state == CLEAR) | (state_next == CLEAR);
    if (state == CLEAR) begin
      we_next = 1'b1;
      wa_next = counter;
      wd_next = '0;
    end else if (grant_a) begin
      we_next = (addr_a != '0);
      wa_next = addr_a;
      wd_next = data_a;
    end else if (grant_b) begin
      we_next = (addr_b != '0);
      wa_next = addr_b;
      wd_next = data_b;
    end
  end

endmodule
